// File: rtl/sd_adc_decimator_pkg.sv
// sd_adc_pkg: shared sizing helpers for the delta-sigma ADC decimator.
//   cic_width(order, dec_log2) : CIC register width that holds R**N without loss
//   excess_mid(out_w)          : mid-scale code of an excess-2**(out_w-1) sample
package sd_adc_pkg;
   function automatic int cic_width(input int order, input int dec_log2);
      return order * dec_log2 + 1;
   endfunction
   function automatic int excess_mid(input int out_w);
      return 1 << (out_w - 1);
   endfunction
   localparam int DEF_OUT_W  = 16;
   localparam int EXCESS_MID = excess_mid(DEF_OUT_W);
endpackage

// File: rtl/sd_adc_decimator_comb.sv
// cic_comb_stage: one CIC comb (y = x - x delayed by one decimated sample).
//   Clk, Reset : clock, asynchronous active-high reset
//   en         : low clears the delay register
//   dstb       : decimation strobe, loads the delay register
//   x, y       : comb input and output, W bits, modulo 2**W
module cic_comb_stage
   import sd_adc_pkg::*;
#(
   parameter int W = 25
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         en,
   input  logic         dstb,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);
   logic [W-1:0] dly;
   assign y = x - dly;
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) dly <= '0;
      else if (!en) dly <= '0;
      else if (dstb) dly <= x;
endmodule

// File: rtl/sd_adc_decimator.sv
// sd_adc_decimator: first-order delta-sigma ADC loop plus CIC decimator with a ready/valid output.
//   Clk, Reset  : modulator clock, asynchronous active-high reset
//   CmpIn       : comparator output (asynchronous), synchronised to bit b
//   En          : run enable; low clears the filter and restarts warm-up
//   FbOut       : feedback bit to the RC network (bare register, IOB-packable)
//   Sample      : decimated excess-2**(OUT_W-1) sample, SampleValid/SampleReady handshake
//   Overrun     : sticky, set when an unaccepted sample is overwritten; OverrunClr clears it
module sd_adc_decimator
   import sd_adc_pkg::*;
#(
   parameter int DEC_LOG2  = 8,
   parameter int CIC_ORDER = 3,
   parameter int OUT_W     = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             CmpIn,
   input  logic             En,
   output logic             FbOut,
   output logic [OUT_W-1:0] Sample,
   output logic             SampleValid,
   input  logic             SampleReady,
   output logic             Overrun,
   input  logic             OverrunClr
);
   localparam int W    = cic_width(CIC_ORDER, DEC_LOG2);
   localparam int SH   = W - 1 - OUT_W;
   localparam int WU_W = $clog2(CIC_ORDER + 1);
   localparam logic [OUT_W-1:0] MID = OUT_W'(excess_mid(OUT_W));
   if (CIC_ORDER * DEC_LOG2 < OUT_W) begin : g_bad_width
      $error("sd_adc_decimator: CIC_ORDER*DEC_LOG2 must be >= OUT_W");
   end
   logic s1, b;
   logic [W-1:0] acc [CIC_ORDER];
   logic [W-1:0] acc_n [CIC_ORDER];
   logic [W-1:0] cc [CIC_ORDER+1];
   logic [DEC_LOG2-1:0] cnt;
   logic [WU_W-1:0] warm;
   logic dstb, fresh;
   logic [OUT_W:0] sw;
   logic [OUT_W-1:0] s;
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) {s1, b, FbOut} <= '0;
      else {s1, b, FbOut} <= {CmpIn, s1, b};
   // Integrator chain computed combinationally so the bit entering on the
   // strobe edge is already part of the sample presented on that edge.
   always_comb begin
      acc_n[0] = acc[0] + W'(b);
      for (int k = 1; k < CIC_ORDER; k++) acc_n[k] = acc[k] + acc_n[k-1];
   end
   always_ff @(posedge Clk or posedge Reset)
      if (Reset || !En) for (int k = 0; k < CIC_ORDER; k++) acc[k] <= '0;
      else acc <= acc_n;
   assign cc[0] = acc_n[CIC_ORDER-1];
   for (genvar i = 0; i < CIC_ORDER; i++) begin : g_comb
      cic_comb_stage #(.W(W)) u_comb (
         .Clk  (Clk),
         .Reset(Reset),
         .en   (En),
         .dstb (dstb),
         .x    (cc[i]),
         .y    (cc[i+1])
      );
   end
   assign dstb  = En & (cnt == '1);
   assign fresh = dstb & (warm == WU_W'(CIC_ORDER));
   // Full-scale ones gives exactly 2**(W-1), one code past the top: clamp it.
   assign sw = cc[CIC_ORDER][W-1:SH];
   assign s  = sw[OUT_W] ? '1 : sw[OUT_W-1:0];
   always_ff @(posedge Clk or posedge Reset)
      if (Reset || !En) begin
         cnt  <= '0;
         warm <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         if (dstb && warm != WU_W'(CIC_ORDER)) warm <= warm + 1'b1;
      end
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         Sample      <= MID;
         SampleValid <= 1'b0;
         Overrun     <= 1'b0;
      end else begin
         if (fresh) begin
            Sample      <= s;
            SampleValid <= 1'b1;
         end else if (SampleValid && SampleReady) SampleValid <= 1'b0;
         if (fresh && SampleValid && !SampleReady) Overrun <= 1'b1;
         else if (OverrunClr) Overrun <= 1'b0;
      end
endmodule

// File: tb/tb_sd_adc_decimator.sv
// tb_sd_adc_decimator: self-checking bench; reference model is a direct FIR
// convolution with the CIC impulse response over the bits since the last restart.
module tb_sd_adc_decimator;
   localparam int R  = 256;
   localparam int N  = 3;
   localparam int HL = N * (R - 1) + 1;
   logic Clk = 1'b0;
   logic Reset, CmpIn, En, FbOut, SampleValid, SampleReady, Overrun, OverrunClr;
   logic [15:0] Sample;
   int total = 0, bad = 0;
   longint h2 [2*R-1];
   longint h [HL];
   logic [3:0] pat;
   int pat_len = 0, phase = 0;
   bit m1, m2, ovr_set, newv;
   logic exp_fb, exp_valid, exp_ovr;
   logic [15:0] exp_sample;
   int mcnt, mwarm;
   bit mq [$];
   longint y, ns;
   always #5 Clk = ~Clk;
   sd_adc_decimator dut (
      .Clk(Clk), .Reset(Reset), .CmpIn(CmpIn), .En(En), .FbOut(FbOut),
      .Sample(Sample), .SampleValid(SampleValid), .SampleReady(SampleReady),
      .Overrun(Overrun), .OverrunClr(OverrunClr)
   );
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m1 = 0; m2 = 0; exp_fb = 0; exp_sample = 16'h8000; exp_valid = 0; exp_ovr = 0;
         mcnt = 0; mwarm = 0; mq.delete();
      end else begin
         newv = 0;
         exp_fb = m2;
         if (En) begin
            mq.push_back(m2);
            if (mq.size() > HL) void'(mq.pop_front());
            mcnt++;
            if (mcnt == R) begin
               mcnt = 0;
               y = 0;
               for (int k = 0; k < mq.size(); k++) y += h[k] * longint'(mq[mq.size()-1-k]);
               if (mwarm < N) mwarm++;
               else begin
                  newv = 1;
                  ns = y >> 8;
                  if (ns > 65535) ns = 65535;
               end
            end
         end else begin
            mq.delete(); mcnt = 0; mwarm = 0;
         end
         ovr_set = newv && exp_valid && !SampleReady;
         if (newv) begin
            exp_sample = 16'(ns); exp_valid = 1;
         end else if (exp_valid && SampleReady) exp_valid = 0;
         if (ovr_set) exp_ovr = 1;
         else if (OverrunClr) exp_ovr = 0;
         m2 = m1; m1 = CmpIn;
      end
   end
   task automatic step();
      @(negedge Clk);
      if (pat_len > 0) begin
         CmpIn = pat[phase % pat_len];
         phase++;
      end
   endtask
   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (!SampleValid && n < limit) begin
         step();
         n++;
      end
   endtask
   task automatic test_reset();
      Reset = 1; En = 0; CmpIn = 0; SampleReady = 0; OverrunClr = 0;
      repeat (3) step();
      total++; if (Sample !== 16'h8000) begin bad++; $display("FAIL reset_sample got=%h want=8000", Sample); end
      total++; if (SampleValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", SampleValid); end
      total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", Overrun); end
      total++; if (FbOut !== 1'b0) begin bad++; $display("FAIL reset_fbout got=%b want=0", FbOut); end
      Reset = 0;
      step();
   endtask
   task automatic test_const_ones();
      int n;
      CmpIn = 1; En = 1; SampleReady = 1; pat_len = 0;
      step(); step();
      total++; if (FbOut !== 1'b0) begin bad++; $display("FAIL ones_fb_early got=%b want=0", FbOut); end
      step();
      total++; if (FbOut !== 1'b1) begin bad++; $display("FAIL ones_fb_3cyc got=%b want=1", FbOut); end
      wait_valid(4 * R + 8, n);
      total++; if (n + 3 != 4 * R) begin bad++; $display("FAIL ones_first_valid cycles=%0d want=%0d", n + 3, 4 * R); end
      total++; if (Sample !== 16'hFFFF) begin bad++; $display("FAIL ones_sample got=%h want=ffff", Sample); end
      for (int j = 0; j < 2; j++) begin
         step();
         total++; if (SampleValid !== 1'b0) begin bad++; $display("FAIL ones_consumed got=%b want=0", SampleValid); end
         wait_valid(R + 4, n);
         total++; if (n + 1 != R) begin bad++; $display("FAIL ones_period cycles=%0d want=%0d", n + 1, R); end
         total++; if (Sample !== 16'hFFFF) begin bad++; $display("FAIL ones_steady got=%h want=ffff", Sample); end
      end
   endtask
   task automatic test_const_zero();
      int n;
      CmpIn = 0; En = 0;
      repeat (5) step();
      En = 1;
      wait_valid(4 * R + 8, n);
      total++; if (n != 4 * R) begin bad++; $display("FAIL zero_first_valid cycles=%0d want=%0d", n, 4 * R); end
      total++; if (Sample !== 16'h0000) begin bad++; $display("FAIL zero_sample got=%h want=0000", Sample); end
      total++; if (Sample !== exp_sample) begin bad++; $display("FAIL zero_model got=%h want=%h", Sample, exp_sample); end
   endtask
   task automatic test_alternating();
      int n;
      En = 0; pat = 4'b0101; pat_len = 2; phase = 0;
      repeat (5) step();
      En = 1;
      wait_valid(4 * R + 8, n);
      total++; if (Sample !== 16'h8000) begin bad++; $display("FAIL alt_sample got=%h want=8000", Sample); end
      step();
      wait_valid(R + 4, n);
      total++; if (Sample !== 16'h8000) begin bad++; $display("FAIL alt_sample2 got=%h want=8000", Sample); end
   endtask
   task automatic test_overrun();
      int n;
      SampleReady = 0;
      n = 0;
      while (!Overrun && n < R + 4) begin step(); n++; end
      total++; if (Overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", Overrun); end
      total++; if (SampleValid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", SampleValid); end
      total++; if (Sample !== exp_sample) begin bad++; $display("FAIL ovr_latest got=%h want=%h", Sample, exp_sample); end
      OverrunClr = 1;
      step();
      OverrunClr = 0;
      total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", Overrun); end
      OverrunClr = 1;
      n = 0;
      while (mcnt != R - 1 && n < R + 4) begin step(); n++; end
      step();
      OverrunClr = 0;
      total++; if (Overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b want=1", Overrun); end
      total++; if (Overrun !== exp_ovr) begin bad++; $display("FAIL ovr_model got=%b want=%b", Overrun, exp_ovr); end
   endtask
   task automatic test_back_to_back();
      int n;
      pat = 4'b0111; pat_len = 4;
      OverrunClr = 1;
      step();
      OverrunClr = 0;
      n = 0;
      while (mcnt != R - 1 && n < R + 4) begin step(); n++; end
      total++; if (SampleValid !== 1'b1) begin bad++; $display("FAIL b2b_pre_valid got=%b want=1", SampleValid); end
      SampleReady = 1;
      step();
      total++; if (SampleValid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", SampleValid); end
      total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", Overrun); end
      total++; if (Sample !== exp_sample) begin bad++; $display("FAIL b2b_sample got=%h want=%h", Sample, exp_sample); end
      step();
      total++; if (SampleValid !== 1'b0) begin bad++; $display("FAIL b2b_consumed got=%b want=0", SampleValid); end
   endtask
   task automatic test_en_gap();
      int n;
      logic [15:0] held;
      pat = 4'b0111; pat_len = 4; SampleReady = 1;
      repeat (37) step();
      held = Sample;
      En = 0;
      repeat (100) step();
      total++; if (SampleValid !== 1'b0) begin bad++; $display("FAIL gap_valid got=%b want=0", SampleValid); end
      total++; if (Sample !== held) begin bad++; $display("FAIL gap_hold got=%h want=%h", Sample, held); end
      En = 1;
      wait_valid(4 * R + 8, n);
      total++; if (n != 4 * R) begin bad++; $display("FAIL gap_warmup cycles=%0d want=%0d", n, 4 * R); end
      total++; if (Sample !== 16'hC000) begin bad++; $display("FAIL gap_sample got=%h want=c000", Sample); end
   endtask
   task automatic test_reset_mid();
      int n;
      SampleReady = 0;
      step();
      wait_valid(R + 4, n);
      repeat (50) step();
      total++; if (SampleValid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%b want=1", SampleValid); end
      #2 Reset = 1;
      #1;
      total++; if (Sample !== 16'h8000) begin bad++; $display("FAIL rmid_sample got=%h want=8000", Sample); end
      total++; if (SampleValid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", SampleValid); end
      total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL rmid_overrun got=%b want=0", Overrun); end
      total++; if (FbOut !== 1'b0) begin bad++; $display("FAIL rmid_fbout got=%b want=0", FbOut); end
      step();
      Reset = 0;
   endtask
   task automatic test_random();
      int dens;
      pat_len = 0; En = 1; dens = 50;
      for (int c = 0; c < 4000; c++) begin
         step();
         total++; if (Sample !== exp_sample) begin bad++; $display("FAIL rnd_sample c=%0d got=%h want=%h", c, Sample, exp_sample); end
         total++; if (SampleValid !== exp_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, SampleValid, exp_valid); end
         total++; if (Overrun !== exp_ovr) begin bad++; $display("FAIL rnd_overrun c=%0d got=%b want=%b", c, Overrun, exp_ovr); end
         total++; if (FbOut !== exp_fb) begin bad++; $display("FAIL rnd_fbout c=%0d got=%b want=%b", c, FbOut, exp_fb); end
         if (c % 500 == 0) dens = $urandom_range(5, 95);
         CmpIn = ($urandom_range(0, 99) < dens);
         SampleReady = ($urandom_range(0, 3) != 0);
         OverrunClr = ($urandom_range(0, 15) == 0);
         En = !(c >= 1500 && c < 1530);
      end
   endtask
   initial begin
      for (int k = 0; k < 2 * R - 1; k++) h2[k] = (k < R) ? k + 1 : 2 * R - 1 - k;
      for (int k = 0; k < HL; k++) begin
         h[k] = 0;
         for (int j = 0; j < R; j++)
            if (k - j >= 0 && k - j < 2 * R - 1) h[k] += h2[k-j];
      end
      test_reset();
      test_const_ones();
      test_const_zero();
      test_alternating();
      test_overrun();
      test_back_to_back();
      test_en_gap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
